// File: rtl/exu_arbiter.sv
// Two-requester arbiter in front of one shared combinational execution unit.
// Each op is registered, issued for one cycle, and its result is held until it is consumed.
package exu_pkg;
    localparam int DATA_WIDTH = 32;

    typedef logic [3:0] func_t;

    localparam func_t FUNC_ADD  = 4'h0;
    localparam func_t FUNC_SUB  = 4'h1;
    localparam func_t FUNC_ADDI = 4'h2;
    localparam func_t FUNC_SLLI = 4'h3;
endpackage

module exu_arbiter
    import exu_pkg::*;
#(
    parameter int DATA_WIDTH = exu_pkg::DATA_WIDTH,
    parameter int RD_WIDTH   = 5
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  req0_valid_i,
    output logic                  req0_ready_o,
    input  func_t                 req0_func_i,
    input  logic [DATA_WIDTH-1:0] req0_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] req0_rs2_data_i,
    input  logic [5:0]            req0_imm_i,
    input  logic [RD_WIDTH-1:0]   req0_rd_addr_i,

    input  logic                  req1_valid_i,
    output logic                  req1_ready_o,
    input  func_t                 req1_func_i,
    input  logic [DATA_WIDTH-1:0] req1_rs1_data_i,
    input  logic [DATA_WIDTH-1:0] req1_rs2_data_i,
    input  logic [5:0]            req1_imm_i,
    input  logic [RD_WIDTH-1:0]   req1_rd_addr_i,

    output func_t                 exu_func_o,
    output logic [DATA_WIDTH-1:0] exu_rs1_data_o,
    output logic [DATA_WIDTH-1:0] exu_rs2_data_o,
    output logic [5:0]            exu_imm_o,
    input  logic [DATA_WIDTH-1:0] exu_result_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_id_o,
    output logic [RD_WIDTH-1:0]   rsp_rd_addr_o,
    output logic [DATA_WIDTH-1:0] rsp_data_o,

    output logic                  busy_o,
    output logic [1:0]            state_o
);

    // Handshakes: a requester op transfers on a rising edge where reqN_valid_i
    // and reqN_ready_o are both high; the response transfers on an edge where
    // rsp_valid_o and rsp_ready_i are both high. Valid never waits on ready.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic                  prio_q;
    logic                  gnt_any;
    logic                  gnt_id;
    logic                  accept_window;
    logic                  accept;

    func_t                 op_func_q;
    logic [DATA_WIDTH-1:0] op_rs1_q;
    logic [DATA_WIDTH-1:0] op_rs2_q;
    logic [5:0]            op_imm_q;
    logic [RD_WIDTH-1:0]   op_rd_q;
    logic                  op_id_q;

    // Round-robin only matters on a tie; a lone requester always wins.
    assign gnt_any       = req0_valid_i | req1_valid_i;
    assign gnt_id        = (req0_valid_i & req1_valid_i) ? prio_q : req1_valid_i;
    assign accept_window = !rst_i && ((state_q == ST_IDLE) ||
                                      ((state_q == ST_HOLD) && rsp_ready_i));
    assign accept        = accept_window && gnt_any;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_HOLD;
            ST_HOLD:  if (rsp_ready_i) state_d = accept ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req0_ready_o = accept && (gnt_id == 1'b0);
        req1_ready_o = accept && (gnt_id == 1'b1);
        busy_o       = (state_q != ST_IDLE);
        state_o      = state_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q    <= 1'b0;
            op_func_q <= '0;
            op_rs1_q  <= '0;
            op_rs2_q  <= '0;
            op_imm_q  <= '0;
            op_rd_q   <= '0;
            op_id_q   <= 1'b0;
        end else if (accept) begin
            prio_q    <= ~gnt_id;
            op_func_q <= gnt_id ? req1_func_i     : req0_func_i;
            op_rs1_q  <= gnt_id ? req1_rs1_data_i : req0_rs1_data_i;
            op_rs2_q  <= gnt_id ? req1_rs2_data_i : req0_rs2_data_i;
            op_imm_q  <= gnt_id ? req1_imm_i      : req0_imm_i;
            op_rd_q   <= gnt_id ? req1_rd_addr_i  : req0_rd_addr_i;
            op_id_q   <= gnt_id;
        end
    end

    // The unit sees only registered operands, so requester inputs never
    // reach exu_result_i combinationally.
    assign exu_func_o     = op_func_q;
    assign exu_rs1_data_o = op_rs1_q;
    assign exu_rs2_data_o = op_rs2_q;
    assign exu_imm_o      = op_imm_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_o   <= 1'b0;
            rsp_id_o      <= 1'b0;
            rsp_rd_addr_o <= '0;
            rsp_data_o    <= '0;
        end else if (state_q == ST_ISSUE) begin
            rsp_valid_o   <= 1'b1;
            rsp_id_o      <= op_id_q;
            rsp_rd_addr_o <= op_rd_q;
            rsp_data_o    <= exu_result_i;
        end else if ((state_q == ST_HOLD) && rsp_ready_i) begin
            rsp_valid_o   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_exu_arbiter.sv
// Directed bench for exu_arbiter with a small behavioural execution unit
// and hand-computed expected responses.
module tb_exu_arbiter;
    import exu_pkg::*;

    localparam int DW = 32;
    localparam int RW = 5;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    func_t         req0_func = '0, req1_func = '0;
    logic [DW-1:0] req0_rs1 = '0, req0_rs2 = '0, req1_rs1 = '0, req1_rs2 = '0;
    logic [5:0]    req0_imm = '0, req1_imm = '0;
    logic [RW-1:0] req0_rd = '0, req1_rd = '0;
    func_t         exu_func;
    logic [DW-1:0] exu_rs1, exu_rs2, exu_result;
    logic [5:0]    exu_imm;
    logic          rsp_valid, rsp_ready = 1'b0, rsp_id;
    logic [RW-1:0] rsp_rd;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic [1:0]    state;

    int checks = 0;
    int failures = 0;

    exu_arbiter #(.DATA_WIDTH(DW), .RD_WIDTH(RW)) dut (
        .clk_i(clk), .rst_i(rst),
        .req0_valid_i(req0_valid), .req0_ready_o(req0_ready), .req0_func_i(req0_func),
        .req0_rs1_data_i(req0_rs1), .req0_rs2_data_i(req0_rs2), .req0_imm_i(req0_imm),
        .req0_rd_addr_i(req0_rd),
        .req1_valid_i(req1_valid), .req1_ready_o(req1_ready), .req1_func_i(req1_func),
        .req1_rs1_data_i(req1_rs1), .req1_rs2_data_i(req1_rs2), .req1_imm_i(req1_imm),
        .req1_rd_addr_i(req1_rd),
        .exu_func_o(exu_func), .exu_rs1_data_o(exu_rs1), .exu_rs2_data_o(exu_rs2),
        .exu_imm_o(exu_imm), .exu_result_i(exu_result),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_rd_addr_o(rsp_rd), .rsp_data_o(rsp_data),
        .busy_o(busy), .state_o(state)
    );

    // clock/reset
    always #5 clk = ~clk;

    // Shared execution unit model; unknown codes return 0.
    always_comb begin
        exu_result = '0;
        case (exu_func)
            FUNC_ADD:  exu_result = exu_rs1 + exu_rs2;
            FUNC_SUB:  exu_result = exu_rs1 - exu_rs2;
            FUNC_ADDI: exu_result = exu_rs1 + {{(DW-6){exu_imm[5]}}, exu_imm};
            FUNC_SLLI: exu_result = exu_rs1 << exu_imm[4:0];
            default:   exu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req0(input logic v, input func_t f, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [5:0] im, input logic [RW-1:0] rd);
        req0_valid = v; req0_func = f; req0_rs1 = a; req0_rs2 = b; req0_imm = im; req0_rd = rd;
        #1;
    endtask

    task automatic drive_req1(input logic v, input func_t f, input logic [DW-1:0] a,
                              input logic [DW-1:0] b, input logic [5:0] im, input logic [RW-1:0] rd);
        req1_valid = v; req1_func = f; req1_rs1 = a; req1_rs2 = b; req1_imm = im; req1_rd = rd;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic [DW-1:0] d,
                             input logic id, input logic [RW-1:0] rd);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"},  rsp_data,       d);
        check({tag, "_id"},    32'(rsp_id),    32'(id));
        check({tag, "_rd"},    32'(rsp_rd),    32'(rd));
    endtask

    initial begin
        // Reset state, with requests pending to see ready held low.
        rst = 1'b1;
        drive_req0(1'b1, FUNC_ADD, 32'd1, 32'd1, 6'd0, 5'd1);
        drive_req1(1'b1, FUNC_ADD, 32'd1, 32'd1, 6'd0, 5'd1);
        tick();
        tick();
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_state",  32'(state),      32'(S_IDLE));
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_valid",  32'(rsp_valid),  32'd0);
        check("rst_data",   rsp_data,        32'd0);
        check("rst_rd",     32'(rsp_rd),     32'd0);
        check("rst_id",     32'(rsp_id),     32'd0);
        check("rst_op_rs1", exu_rs1,         32'd0);
        drive_req0(1'b0, FUNC_ADD, '0, '0, '0, '0);
        drive_req1(1'b0, FUNC_ADD, '0, '0, '0, '0);
        rst = 1'b0;
        #1;

        // Idle without requests stays idle.
        tick();
        check("idle_state", 32'(state), 32'(S_IDLE));

        // Single ADD on req0 with one-cycle issue latency.
        rsp_ready = 1'b1;
        drive_req0(1'b1, FUNC_ADD, 32'd5, 32'd7, 6'd0, 5'd3);
        check("add_ready0", 32'(req0_ready), 32'd1);
        check("add_ready1", 32'(req1_ready), 32'd0);
        tick();
        drive_req0(1'b0, FUNC_ADD, '0, '0, '0, '0);
        check("add_issue_state", 32'(state),     32'(S_ISSUE));
        check("add_issue_valid", 32'(rsp_valid), 32'd0);
        check("add_issue_busy",  32'(busy),      32'd1);
        check("add_exu_rs1",     exu_rs1,        32'd5);
        tick();
        check_rsp("add", 32'd12, 1'b0, 5'd3);
        check("add_hold_state", 32'(state), 32'(S_HOLD));
        tick();
        check("add_done_valid", 32'(rsp_valid), 32'd0);
        check("add_done_state", 32'(state),     32'(S_IDLE));
        check("add_exu_hold",   exu_rs1,        32'd5);

        // Both requesting from reset: req0 first, then req1.
        do_reset();
        drive_req0(1'b1, FUNC_SUB,  32'd10, 32'd4, 6'd0,  5'd1);
        drive_req1(1'b1, FUNC_ADDI, 32'd1,  32'd0, 6'h3F, 5'd2);
        check("tie_ready0", 32'(req0_ready), 32'd1);
        check("tie_ready1", 32'(req1_ready), 32'd0);
        tick();
        check("tie_issue_ready1", 32'(req1_ready), 32'd0);
        tick();
        check_rsp("tie_first", 32'd6, 1'b0, 5'd1);
        check("tie_alt_ready0", 32'(req0_ready), 32'd0);
        check("tie_alt_ready1", 32'(req1_ready), 32'd1);
        tick();
        drive_req0(1'b0, FUNC_ADD, '0, '0, '0, '0);
        drive_req1(1'b0, FUNC_ADD, '0, '0, '0, '0);
        check("tie_b2b_state", 32'(state), 32'(S_ISSUE));
        tick();
        check_rsp("tie_second", 32'd0, 1'b1, 5'd2);
        tick();
        check("tie_idle", 32'(state), 32'(S_IDLE));

        // Back-pressure: response held five cycles, then retires with a new accept.
        rsp_ready = 1'b0;
        drive_req0(1'b1, FUNC_ADD, 32'd2, 32'd3, 6'd0, 5'd7);
        tick();
        drive_req0(1'b0, FUNC_ADD, '0, '0, '0, '0);
        drive_req1(1'b1, FUNC_ADD, 32'd1, 32'd1, 6'd0, 5'd4);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_rsp("bp_hold", 32'd5, 1'b0, 5'd7);
            check("bp_ready1", 32'(req1_ready), 32'd0);
            check("bp_busy",   32'(busy),       32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_release_ready1", 32'(req1_ready), 32'd1);
        tick();
        drive_req1(1'b0, FUNC_ADD, '0, '0, '0, '0);
        check("bp_b2b_state", 32'(state),     32'(S_ISSUE));
        check("bp_b2b_valid", 32'(rsp_valid), 32'd0);
        tick();
        check_rsp("bp_next", 32'd2, 1'b1, 5'd4);
        tick();
        check("bp_idle", 32'(state), 32'(S_IDLE));

        // Continuous SLLI on req1: one response every two cycles.
        drive_req1(1'b1, FUNC_SLLI, 32'd1, 32'd0, 6'd4, 5'd9);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("sll_issue_state", 32'(state),     32'(S_ISSUE));
            check("sll_issue_valid", 32'(rsp_valid), 32'd0);
            tick();
            check_rsp("sll", 32'd16, 1'b1, 5'd9);
            if (i == 3) drive_req1(1'b0, FUNC_ADD, '0, '0, '0, '0);
            tick();
        end
        check("sll_idle", 32'(state), 32'(S_IDLE));

        // Reset during ISSUE drops the operation.
        drive_req0(1'b1, FUNC_ADD, 32'd9, 32'd9, 6'd0, 5'd5);
        tick();
        drive_req0(1'b0, FUNC_ADD, '0, '0, '0, '0);
        check("rst_issue_state", 32'(state), 32'(S_ISSUE));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drop_state", 32'(state),     32'(S_IDLE));
        check("drop_valid", 32'(rsp_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("drop_no_rsp", 32'(rsp_valid), 32'd0);
            check("drop_data",   rsp_data,       32'd0);
        end

        // Undefined function code returns zero and completes normally.
        drive_req0(1'b1, 4'hF, 32'd3, 32'd3, 6'd0, 5'd6);
        tick();
        drive_req0(1'b0, FUNC_ADD, '0, '0, '0, '0);
        check("inv_func_pass", 32'(exu_func), 32'hF);
        tick();
        check_rsp("inv", 32'd0, 1'b0, 5'd6);
        tick();
        check("inv_idle", 32'(state), 32'(S_IDLE));
        check("inv_busy", 32'(busy),  32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
